// File: rtl/acorn128_pkg.sv
// rtl/acorn128_pkg.sv - ACORN-128 shared constants, tap indices, step boundaries and majority helper
package acorn128_pkg;

    localparam int STATE_W = 293;
    localparam int STEP_W  = 12;

    // State tap indices used by the feedback function
    localparam int TAP_S0   = 0;
    localparam int TAP_S23  = 23;
    localparam int TAP_S107 = 107;
    localparam int TAP_S160 = 160;
    localparam int TAP_S196 = 196;
    localparam int TAP_S244 = 244;

    // Step-counter boundaries for the AD and encryption phases
    localparam logic [STEP_W-1:0] AD_START  = 12'd0;
    localparam logic [STEP_W-1:0] AD_PAD    = 12'd128;
    localparam logic [STEP_W-1:0] AD_CA0    = 12'd256;
    localparam logic [STEP_W-1:0] ENC_START = 12'd384;
    localparam logic [STEP_W-1:0] ENC_PAD   = 12'd512;
    localparam logic [STEP_W-1:0] ENC_CA0   = 12'd640;
    localparam logic [STEP_W-1:0] ENC_END   = 12'd767;

    // Length of a data window (AD or plaintext) in steps
    localparam logic [STEP_W-1:0] DATA_LEN  = 12'd128;

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/acorn128_ad_enc_ctrl_if.sv
// rtl/acorn128_ad_enc_ctrl_if.sv - feedback bus between the control decoder and the feedback block
//  state : current ACORN state S[292:0]
//  ks    : keystream bit for the current step
//  ca/cb : registered control bits
//  f     : feedback bit returned by the feedback block
//  master drives state/ks/ca/cb and reads f; slave is the reverse.
interface acorn128_ad_enc_ctrl_if;
    import acorn128_pkg::*;

    logic [STATE_W-1:0] state;
    logic               ks;
    logic               ca;
    logic               cb;
    logic               f;

    modport master (output state, output ks, output ca, output cb, input f);
    modport slave  (input state, input ks, input ca, input cb, output f);

endinterface

// File: rtl/acorn128_fbk.sv
// rtl/acorn128_fbk.sv - combinational ACORN-128 feedback bit
//  bus (slave) : state, ks, ca, cb in; f out
//  f = S0 ^ ~S107 ^ maj(S244,S23,S160) ^ (ca & S196) ^ (cb & ks)
module acorn128_fbk
    import acorn128_pkg::*;
(
    acorn128_ad_enc_ctrl_if.slave bus
);

    // Only six taps feed the equation; the rest of the state is intentionally ignored
    logic unused_state;
    assign unused_state = ^bus.state;

    always_comb begin
        bus.f = bus.state[TAP_S0]
              ^ ~bus.state[TAP_S107]
              ^ maj(bus.state[TAP_S244], bus.state[TAP_S23], bus.state[TAP_S160])
              ^ (bus.ca & bus.state[TAP_S196])
              ^ (bus.cb & bus.ks);
    end

endmodule

// File: rtl/acorn128_ad_enc_ctrl.sv
// rtl/acorn128_ad_enc_ctrl.sv - ACORN-128 AD/encryption control-bit decoder and feedback generator
//  clk, rst        : clock, synchronous active-low reset
//  count_in        : global step counter (AD 0..383, encryption 384..767)
//  ad_in           : associated data, bit i used at step i
//  plaintext_in    : plaintext, bit i used at step 384+i
//  state_in, ks_in : current state and keystream bit
//  ca_out, cb_out, mbit_out, valid_out : registered decode of the previous cycle's count
//  fbk_out, s292_out : combinational feedback and new top state bit
module acorn128_ad_enc_ctrl
    import acorn128_pkg::*;
#(
    parameter int CNT_W    = 12,
    parameter int AD_BITS  = 128,
    parameter int MSG_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CNT_W-1:0]    count_in,
    input  logic [AD_BITS-1:0]  ad_in,
    input  logic [MSG_BITS-1:0] plaintext_in,
    input  logic [STATE_W-1:0]  state_in,
    input  logic                ks_in,
    output logic                ca_out,
    output logic                cb_out,
    output logic                mbit_out,
    output logic                valid_out,
    output logic                fbk_out,
    output logic                s292_out
);

    logic             ca_d;
    logic             cb_d;
    logic             m_d;
    logic             v_d;
    logic [CNT_W-1:0] enc_idx;

    always_comb begin
        ca_d    = 1'b0;
        cb_d    = 1'b0;
        m_d     = 1'b0;
        v_d     = 1'b0;
        // Wraps for counts below ENC_START; only consulted inside the encryption window
        enc_idx = count_in - ENC_START;
        if (count_in < ENC_START) begin
            v_d  = 1'b1;
            cb_d = 1'b1;
            ca_d = (count_in < AD_CA0);
            if (count_in < AD_PAD) begin
                m_d = ad_in[count_in[6:0]];
            end else if (count_in == AD_PAD) begin
                m_d = 1'b1;
            end
        end else if (count_in <= ENC_END) begin
            v_d  = 1'b1;
            ca_d = (count_in < ENC_CA0);
            if (enc_idx < DATA_LEN) begin
                m_d = plaintext_in[enc_idx[6:0]];
            end else if (count_in == ENC_PAD) begin
                m_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ca_out    <= 1'b0;
            cb_out    <= 1'b0;
            mbit_out  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            ca_out    <= ca_d;
            cb_out    <= cb_d;
            mbit_out  <= m_d;
            valid_out <= v_d;
        end
    end

    acorn128_ad_enc_ctrl_if fbk_bus ();

    assign fbk_bus.state = state_in;
    assign fbk_bus.ks    = ks_in;
    assign fbk_bus.ca    = ca_out;
    assign fbk_bus.cb    = cb_out;

    acorn128_fbk u_fbk (
        .bus (fbk_bus.slave)
    );

    assign fbk_out  = fbk_bus.f;
    assign s292_out = fbk_bus.f ^ mbit_out;

endmodule

// File: tb/tb_acorn128_ad_enc_ctrl.sv
// tb/tb_acorn128_ad_enc_ctrl.sv - self-checking bench for acorn128_ad_enc_ctrl
module tb_acorn128_ad_enc_ctrl;
    import acorn128_pkg::*;

    logic               clk;
    logic               rst;
    logic [11:0]        count_in;
    logic [127:0]       ad_in;
    logic [127:0]       plaintext_in;
    logic [STATE_W-1:0] state_in;
    logic               ks_in;
    logic               ca_out;
    logic               cb_out;
    logic               mbit_out;
    logic               valid_out;
    logic               fbk_out;
    logic               s292_out;

    int errors = 0;
    int checks = 0;

    acorn128_ad_enc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .count_in     (count_in),
        .ad_in        (ad_in),
        .plaintext_in (plaintext_in),
        .state_in     (state_in),
        .ks_in        (ks_in),
        .ca_out       (ca_out),
        .cb_out       (cb_out),
        .mbit_out     (mbit_out),
        .valid_out    (valid_out),
        .fbk_out      (fbk_out),
        .s292_out     (s292_out)
    );

    // Standalone feedback block driven through the interface
    acorn128_ad_enc_ctrl_if fbk_bus ();
    acorn128_fbk u_fbk_alone (
        .bus (fbk_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]  count;
        logic [127:0] ad;
        logic [127:0] pt;
        logic         ca;
        logic         cb;
        logic         m;
        logic         v;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name, input logic ca, input logic cb,
                              input logic m, input logic v);
        check({name, ".ca"}, ca_out, ca);
        check({name, ".cb"}, cb_out, cb);
        check({name, ".m"}, mbit_out, m);
        check({name, ".valid"}, valid_out, v);
        check({name, ".s292"}, s292_out, fbk_out ^ m);
    endtask

    task automatic step(input logic [11:0] cnt);
        @(negedge clk);
        count_in = cnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] pt_ends;
        logic [127:0] ad_100;
        pt_ends = {1'b1, 126'd0, 1'b1};
        ad_100  = 128'h5;
        ad_100[100] = 1'b1;

        // AD window, ad = 0x5
        vecs[0]  = '{12'd0,    128'h5, '0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{12'd1,    128'h5, '0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{12'd2,    128'h5, '0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{12'd128,  128'h5, '0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{12'd200,  128'h5, '0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{12'd256,  128'h5, '0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{12'd383,  128'h5, '0, 1'b0, 1'b1, 1'b0, 1'b1};
        // Encryption window, plaintext bits 0 and 127 set
        vecs[7]  = '{12'd384,  '1, pt_ends, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{12'd511,  '1, pt_ends, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{12'd512,  '1, pt_ends, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{12'd600,  '1, pt_ends, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{12'd640,  '1, pt_ends, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{12'd767,  '1, pt_ends, 1'b0, 1'b0, 1'b0, 1'b1};
        // Out of range
        vecs[13] = '{12'd768,  '1, '1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{12'd4095, '1, '1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst          = 1'b0;
        count_in     = 12'd0;
        ad_in        = '1;
        plaintext_in = '0;
        state_in     = '0;
        ks_in        = 1'b0;
        fbk_bus.state = '0;
        fbk_bus.ks    = 1'b0;
        fbk_bus.ca    = 1'b0;
        fbk_bus.cb    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_regs("release", 1'b1, 1'b1, 1'b1, 1'b1);

        // Table-driven decode
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            count_in     = vecs[k].count;
            ad_in        = vecs[k].ad;
            plaintext_in = vecs[k].pt;
            @(posedge clk);
            #1;
            check_regs($sformatf("vec%0d_cnt%0d", k, vecs[k].count),
                       vecs[k].ca, vecs[k].cb, vecs[k].m, vecs[k].v);
        end

        // Feedback with ca=cb=0
        ad_in = '0;
        step(12'd700);
        check_regs("cnt700", 1'b0, 1'b0, 1'b0, 1'b1);
        state_in = '0;
        #1 check("fbk_zero", fbk_out, 1'b1);
        check("s292_zero", s292_out, 1'b1);
        state_in[0] = 1'b1;
        #1 check("fbk_s0", fbk_out, 1'b0);
        state_in = '0;
        state_in[23] = 1'b1;
        state_in[160] = 1'b1;
        #1 check("fbk_maj", fbk_out, 1'b0);
        // ca/cb gated off: S196 and ks must not contribute
        state_in = '0;
        state_in[196] = 1'b1;
        ks_in = 1'b1;
        #1 check("fbk_gated", fbk_out, 1'b1);

        // Feedback with ca=cb=1 (count 0, ad bit 0 clear so m=0)
        step(12'd0);
        check_regs("cnt0", 1'b1, 1'b1, 1'b0, 1'b1);
        #1 check("fbk_ca_cb", fbk_out, 1'b1);
        ks_in = 1'b0;
        #1 check("fbk_ca_only", fbk_out, 1'b0);
        check("s292_ca_only", s292_out, 1'b0);

        // Mid-operation reset at count 100, then resume
        ad_in = ad_100;
        @(negedge clk);
        count_in = 12'd100;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_regs("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_regs("resume100", 1'b1, 1'b1, 1'b1, 1'b1);

        // Standalone feedback block through the interface
        fbk_bus.state = '0;
        fbk_bus.state[196] = 1'b1;
        fbk_bus.ca = 1'b1;
        #1 check("if_fbk_ca", fbk_bus.f, 1'b0);
        fbk_bus.state = '0;
        fbk_bus.state[107] = 1'b1;
        fbk_bus.ca = 1'b0;
        fbk_bus.cb = 1'b1;
        fbk_bus.ks = 1'b1;
        #1 check("if_fbk_cb", fbk_bus.f, 1'b1);
        fbk_bus.state[244] = 1'b1;
        fbk_bus.state[23] = 1'b1;
        #1 check("if_fbk_maj", fbk_bus.f, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
